rast_hit_buffer: RTL
====================

Name: rast_hit_buffer

Overview:
- Downstream of the rasterizer output (hit_R18S / color_R18U / hit_valid_R18H).
- The rasterizer cannot be back-pressured at its output, so this block captures every hit sample into a show-ahead FIFO.
- It re-issues the samples over a valid/ready interface to the framebuffer/dump consumer.
- It flags near-full so integration can throttle triangle issue, and it counts accepted and dropped hits.

Parameters:
- SIGFIG, 24, bits per coordinate/colour word (from rast_params)
- AXIS, 3, coordinates per hit (x, y, z)
- COLORS, 3, colour channels per hit
- DEPTH, 16, FIFO entries (power of two, >=4)
- AFULL_SLACK, 4, almost_full asserts when occupancy >= DEPTH-AFULL_SLACK
- CNT_W, 32, width of hit/drop counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- hit_R18S  in  signed [SIGFIG-1:0] x AXIS  sample location from rast
- color_R18U  in  unsigned [SIGFIG-1:0] x COLORS  sample colour from rast
- hit_valid_R18H  in  1  sample hit qualifier
- out_hit_S  out  signed [SIGFIG-1:0] x AXIS  head-entry location
- out_color_U  out  unsigned [SIGFIG-1:0] x COLORS  head-entry colour
- out_valid_H  out  1  head entry valid
- out_ready_H  in  1  consumer accepts head
- almost_full_H  out  1  occupancy >= DEPTH-AFULL_SLACK
- overflow_H  out  1  sticky: a hit was dropped
- hit_count_U  out  CNT_W  accepted hits, saturating
- drop_count_U  out  CNT_W  dropped hits, saturating
- clear_stats_H  in  1  synchronous clear of counters and overflow_H

Behaviour:
- Reset:
  - Asynchronous, active-high. Pointers, occupancy, counters and overflow_H are cleared to 0.
  - out_valid_H=0 and almost_full_H=0. Data outputs are 0.
  - Reset mid-operation discards all buffered entries, with no partial pop.
- push = hit_valid_R18H & (~full | pop).
- pop = out_valid_H & out_ready_H.
- Entry = {hit, colour}, (AXIS+COLORS)*SIGFIG bits, stored unmodified with no arithmetic on the payload.
- Show-ahead FIFO:
  - out_valid_H = (occupancy != 0).
  - out_hit_S/out_color_U are driven by a register image of the head entry and are stable while out_valid_H & ~out_ready_H.
  - Latency: a hit pushed at edge N into an empty FIFO shows out_valid_H=1 after edge N (visible in cycle N+1). There is no fall-through within the same cycle.
- Occupancy:
  - Counter width clog2(DEPTH)+1.
  - push&~pop: +1. pop&~push: -1. Both or neither: unchanged.
- Pointers: read/write pointers are clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Full:
  - Simultaneous push and pop at full is accepted. Occupancy stays DEPTH and the head advances.
  - hit_valid_R18H at full without pop is a drop. The entry is discarded, overflow_H is set, and drop_count_U increments.
- Empty: pop cannot occur because out_valid_H=0. A push into an empty FIFO while out_ready_H=1 is not popped in the same cycle.
- almost_full_H is registered and reflects next-state occupancy, so it is valid the cycle after the causing edge.
- Counters:
  - hit_count_U increments on every push. drop_count_U increments on every drop.
  - Both saturate at 2^CNT_W-1.
- clear_stats_H:
  - Zeroes both counters and overflow_H at the next edge. If a push or drop occurs in the same cycle, clear wins (count=0).
  - Does not affect FIFO contents.
- hit_valid_R18H=0 cycles carry don't-care payload and are never stored.

Decomposition:
- rast_params supplies SIGFIG, AXIS, COLORS.
- Add to rast_params:
  - typedef hit_entry_t, a packed struct {hit[AXIS], color[COLORS]}
  - localparams HITBUF_DEPTH and HITBUF_AFULL_SLACK
- One sub-module, rast_hit_fifo_mem: a DEPTH x entry-width register array with one write port and a registered head-read path.
- The top holds pointers, occupancy, flags and counters.

Test Plan:
- Reset then idle, with hit_valid_R18H=0 for 20 cycles:
  - Expect out_valid_H=0, hit_count_U=0, almost_full_H=0.
- Single hit x=0x000400, y=0x000800, z=0, colour {0xFFF000,0,0} at edge 5, with out_ready_H=1:
  - Expect out_valid_H=1 in cycle 6 with identical payload.
  - Popped at edge 6; out_valid_H=0 in cycle 7. hit_count_U=1.
- DEPTH=16, AFULL_SLACK=4, out_ready_H=0, 12 consecutive hits (x=1..12):
  - almost_full_H rises the cycle after the 12th push.
  - 4 more hits fill the FIFO. A 17th hit sets overflow_H=1 and drop_count_U=1.
  - Draining returns x=1..16 in order.
- At full, present a hit together with out_ready_H=1:
  - Hit accepted, occupancy stays 16, no drop.
  - Head changes from x=1 to x=2.
- Random hit_valid (50%) and out_ready (30%) for 10,000 cycles against a scoreboard queue:
  - Exact in-order match.
  - hit_count_U equals popped plus resident entries.
  - drop_count_U equals scoreboard drops.
- Assert rst with 7 entries buffered:
  - out_valid_H=0 immediately (asynchronous) and counters=0.
  - After release, the next hit is the first output.
- Assert clear_stats_H while a drop occurs:
  - overflow_H=0 and drop_count_U=0 next cycle. FIFO contents are unaffected.

Source files
------------

// File: rtl/rast_params.sv
// rast_params: shared rasterizer word sizes plus hit-buffer entry type and sizing
package rast_params;
  localparam int SIGFIG = 24;
  localparam int AXIS = 3;
  localparam int COLORS = 3;
  localparam int HITBUF_DEPTH = 16;
  localparam int HITBUF_AFULL_SLACK = 4;
  typedef struct packed {
    logic [AXIS-1:0][SIGFIG-1:0] hit;
    logic [COLORS-1:0][SIGFIG-1:0] color;
  } hit_entry_t;
endpackage

// File: rtl/rast_hit_fifo_mem.sv
// rast_hit_fifo_mem: DEPTH x hit_entry_t register array with one write port and a registered head image
//   clk/rst                   clock, async active-high reset (clears head image only)
//   wr_en/wr_addr/wr_data     write port
//   rd_load/rd_addr           reload head image from rd_addr (bypassing a same-cycle write to it)
//   head                      registered head entry
module rast_hit_fifo_mem
  import rast_params::*;
#(
  parameter int DEPTH = HITBUF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  hit_entry_t    wr_data,
  input  logic          rd_load,
  input  logic [AW-1:0] rd_addr,
  output hit_entry_t    head
);
  hit_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // the only time the next head is being written this edge is a push into an
  // otherwise-empty FIFO, so forward the write data instead of the stale cell
  always_ff @(posedge clk or posedge rst)
    if (rst) head <= '0;
    else if (rd_load) head <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
endmodule

// File: rtl/rast_hit_buffer.sv
// rast_hit_buffer: show-ahead FIFO capturing every rasterizer hit and replaying it over valid/ready
//   hit_R18S/color_R18U/hit_valid_R18H   unthrottled sample stream from the rasterizer
//   out_hit_S/out_color_U/out_valid_H    registered head entry, popped by out_ready_H
//   almost_full_H                        registered, occupancy >= DEPTH-AFULL_SLACK
//   overflow_H/hit_count_U/drop_count_U  sticky drop flag and saturating counters
//   clear_stats_H                        synchronous clear of counters and overflow_H
module rast_hit_buffer
  import rast_params::*;
#(
  parameter int DEPTH = HITBUF_DEPTH,
  parameter int AFULL_SLACK = HITBUF_AFULL_SLACK,
  parameter int CNT_W = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [AXIS-1:0][SIGFIG-1:0] hit_R18S,
  input  logic [COLORS-1:0][SIGFIG-1:0]      color_R18U,
  input  logic                               hit_valid_R18H,
  output logic signed [AXIS-1:0][SIGFIG-1:0] out_hit_S,
  output logic [COLORS-1:0][SIGFIG-1:0]      out_color_U,
  output logic                               out_valid_H,
  input  logic                               out_ready_H,
  output logic                               almost_full_H,
  output logic                               overflow_H,
  output logic [CNT_W-1:0]                   hit_count_U,
  output logic [CNT_W-1:0]                   drop_count_U,
  input  logic                               clear_stats_H
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0] occ, occ_next;
  logic full, push, pop, drop, head_load;
  hit_entry_t wr_data, head;
  assign wr_data = '{hit: hit_R18S, color: color_R18U};
  assign out_valid_H = occ != '0;
  assign full = occ == (AW+1)'(DEPTH);
  assign pop = out_valid_H & out_ready_H;
  assign push = hit_valid_R18H & (~full | pop);
  assign drop = hit_valid_R18H & full & ~pop;
  assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign occ_next = (push & ~pop) ? occ + (AW+1)'(1) : (pop & ~push) ? occ - (AW+1)'(1) : occ;
  // refresh the head image whenever the head moves or an empty FIFO gets its first entry
  assign head_load = (occ_next != '0) & (pop | ~out_valid_H);
  assign out_hit_S = head.hit;
  assign out_color_U = head.color;
  rast_hit_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_load(head_load),
    .rd_addr(rd_next),
    .head(head)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      almost_full_H <= 1'b0;
      overflow_H <= 1'b0;
      hit_count_U <= '0;
      drop_count_U <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_next;
      occ <= occ_next;
      almost_full_H <= occ_next >= (AW+1)'(DEPTH - AFULL_SLACK);
      overflow_H <= ~clear_stats_H & (overflow_H | drop);
      hit_count_U <= clear_stats_H ? '0 : (push && hit_count_U != '1) ? hit_count_U + CNT_W'(1) : hit_count_U;
      drop_count_U <= clear_stats_H ? '0 : (drop && drop_count_U != '1) ? drop_count_U + CNT_W'(1) : drop_count_U;
    end
endmodule
